// File: rtl/mips_debug_ctrl.sv
// ============================================================================
//  Module      : mips_debug_ctrl
//  Description : Host debug controller between the UART byte link and the
//                MIPS pipeline. Decodes command bytes, loads program words
//                into instruction memory, runs or single-steps the CPU, and
//                streams PC, register file and data memory back to the host.
//
//  Ports
//    basys_clk / basys_reset      : clock (rising edge), async active-low reset
//    i_rx_data / i_rx_valid       : received command/data byte and strobe
//    o_tx_data / o_tx_valid /
//    i_tx_ready                   : transmit byte stream, valid/ready handshake
//    o_im_we / o_im_addr /
//    o_im_wdata                   : instruction-memory write port
//    o_cpu_en / o_cpu_rst         : pipeline clock-enable and reset pulse
//    i_halt / i_pc                : HALT reached write-back, current PC
//    o_reg_addr / i_reg_data      : register-file debug read (1-cycle latency)
//    o_mem_addr / i_mem_data      : data-memory debug read (1-cycle latency)
//    o_busy                       : high whenever the controller is not idle
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_debug_ctrl #(
    parameter int NBITS      = 32,
    parameter int CELDAS_REG = 32,
    parameter int CELDAS_M   = 70,
    parameter int IM_ABITS   = 8,
    parameter int RBITS      = 5,
    parameter int MBITS      = 7
) (
    input  logic                 basys_clk,
    input  logic                 basys_reset,
    input  logic [7:0]           i_rx_data,
    input  logic                 i_rx_valid,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic                 o_im_we,
    output logic [IM_ABITS-1:0]  o_im_addr,
    output logic [NBITS-1:0]     o_im_wdata,
    output logic                 o_cpu_en,
    output logic                 o_cpu_rst,
    input  logic                 i_halt,
    input  logic [NBITS-1:0]     i_pc,
    output logic [RBITS-1:0]     o_reg_addr,
    input  logic [NBITS-1:0]     i_reg_data,
    output logic [MBITS-1:0]     o_mem_addr,
    input  logic [NBITS-1:0]     i_mem_data,
    output logic                 o_busy
);

    // Command bytes
    localparam logic [7:0] c_CMD_LOAD  = 8'h4C;
    localparam logic [7:0] c_CMD_STEP  = 8'h53;
    localparam logic [7:0] c_CMD_RUN   = 8'h43;
    localparam logic [7:0] c_CMD_RESET = 8'h52;

    // Dump is one PC word, then every register, then every memory word
    localparam int c_WORDS = 1 + CELDAS_REG + CELDAS_M;
    localparam int c_CW    = ($clog2(c_WORDS + 1) > 8) ? $clog2(c_WORDS + 1) : 8;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LD_CNT    = 3'd1;
    localparam logic [2:0] S_LD_BYTE   = 3'd2;
    localparam logic [2:0] S_STEP      = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_DUMP_WAIT = 3'd5;  // read address settling
    localparam logic [2:0] S_DUMP_CAP  = 3'd6;  // read data valid, capture
    localparam logic [2:0] S_DUMP_TX   = 3'd7;  // shift bytes out

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_CW-1:0]     r_word;      // load word index / dump word index
    logic [c_CW-1:0]     w_word_inc;
    logic [7:0]          r_count;     // words to load
    logic [1:0]          r_byte;      // byte index within a word
    logic [NBITS-1:0]    r_shift;
    logic [NBITS-1:0]    w_cap_data;
    logic [7:0]          r_tx_data;
    logic                r_tx_valid;
    logic                r_im_we;
    logic [IM_ABITS-1:0] r_im_addr;
    logic [NBITS-1:0]    r_im_wdata;
    logic                r_cpu_en;
    logic                r_cpu_rst;
    logic [RBITS-1:0]    r_reg_addr;
    logic [MBITS-1:0]    r_mem_addr;
    logic                r_busy;

    logic                w_tx_fire;
    logic                w_last_byte;
    logic                w_last_word;
    logic                w_load_done;
    logic                w_is_pc;
    logic                w_is_reg;

    assign w_word_inc  = r_word + c_CW'(1);
    assign w_tx_fire   = r_tx_valid & i_tx_ready;
    assign w_last_byte = (r_byte == 2'd3);
    assign w_last_word = (r_word == c_CW'(c_WORDS - 1));
    assign w_load_done = (w_word_inc == c_CW'(r_count));
    assign w_is_pc     = (r_word == '0);
    assign w_is_reg    = !w_is_pc && (r_word <= c_CW'(CELDAS_REG));

    // Word 0 comes from the PC snapshot already held in the shift register
    always_comb begin
        w_cap_data = i_mem_data;
        if (w_is_pc) begin
            w_cap_data = r_shift;
        end else if (w_is_reg) begin
            w_cap_data = i_reg_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == c_CMD_LOAD) begin
                        w_state_nxt = S_LD_CNT;
                    end else if (i_rx_data == c_CMD_STEP) begin
                        w_state_nxt = S_STEP;
                    end else if (i_rx_data == c_CMD_RUN) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_LD_CNT: begin
                if (i_rx_valid) begin
                    w_state_nxt = (i_rx_data == 8'h00) ? S_IDLE : S_LD_BYTE;
                end
            end
            S_LD_BYTE: begin
                if (i_rx_valid && w_last_byte && w_load_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_STEP:      w_state_nxt = S_DUMP_WAIT;
            S_RUN: begin
                if (i_halt) begin
                    w_state_nxt = S_DUMP_WAIT;
                end
            end
            S_DUMP_WAIT: w_state_nxt = S_DUMP_CAP;
            S_DUMP_CAP:  w_state_nxt = S_DUMP_TX;
            S_DUMP_TX: begin
                if (w_tx_fire && w_last_byte) begin
                    w_state_nxt = w_last_word ? S_IDLE : S_DUMP_WAIT;
                end
            end
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge basys_clk or negedge basys_reset) begin
        if (!basys_reset) begin
            r_state    <= S_IDLE;
            r_word     <= '0;
            r_count    <= '0;
            r_byte     <= '0;
            r_shift    <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
            r_cpu_en   <= 1'b0;
            r_cpu_rst  <= 1'b0;
            r_reg_addr <= '0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            // Strobes are single-cycle unless re-asserted below
            r_im_we   <= 1'b0;
            r_cpu_en  <= 1'b0;
            r_cpu_rst <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_rx_valid) begin
                        // Enable starts the cycle after the run command,
                        // unless the CPU is already halted
                        if (i_rx_data == c_CMD_RUN) begin
                            r_cpu_en <= ~i_halt;
                        end
                        if (i_rx_data == c_CMD_RESET) begin
                            r_cpu_rst <= 1'b1;
                        end
                    end
                end
                S_LD_CNT: begin
                    if (i_rx_valid) begin
                        r_count <= i_rx_data;
                        r_word  <= '0;
                        r_byte  <= '0;
                    end
                end
                S_LD_BYTE: begin
                    if (i_rx_valid) begin
                        r_shift <= {r_shift[NBITS-9:0], i_rx_data};
                        r_byte  <= r_byte + 2'd1;
                        if (w_last_byte) begin
                            r_im_we    <= 1'b1;
                            r_im_addr  <= r_word[IM_ABITS-1:0];
                            r_im_wdata <= {r_shift[NBITS-9:0], i_rx_data};
                            r_word     <= w_word_inc;
                        end
                    end
                end
                S_STEP: begin
                    r_cpu_en   <= ~i_halt;
                    r_word     <= '0;
                    r_reg_addr <= '0;
                    r_mem_addr <= '0;
                end
                S_RUN: begin
                    r_cpu_en <= ~i_halt;
                    if (i_halt) begin
                        r_word     <= '0;
                        r_reg_addr <= '0;
                        r_mem_addr <= '0;
                    end
                end
                S_DUMP_WAIT: begin
                    if (w_is_pc) begin
                        r_shift <= i_pc;
                    end
                end
                S_DUMP_CAP: begin
                    r_shift    <= w_cap_data;
                    r_tx_data  <= w_cap_data[NBITS-1 -: 8];
                    r_tx_valid <= 1'b1;
                    r_byte     <= '0;
                    // Advance the read address now so it is stable well
                    // before the next word's capture
                    if (w_is_reg) begin
                        r_reg_addr <= (r_reg_addr == RBITS'(CELDAS_REG - 1)) ?
                                      '0 : r_reg_addr + RBITS'(1);
                    end else if (!w_is_pc) begin
                        r_mem_addr <= (r_mem_addr == MBITS'(CELDAS_M - 1)) ?
                                      '0 : r_mem_addr + MBITS'(1);
                    end
                end
                S_DUMP_TX: begin
                    if (w_tx_fire) begin
                        if (w_last_byte) begin
                            r_tx_valid <= 1'b0;
                            r_word     <= w_word_inc;
                        end else begin
                            r_byte    <= r_byte + 2'd1;
                            r_tx_data <= r_shift[NBITS-9 -: 8];
                            r_shift   <= {r_shift[NBITS-9:0], 8'h00};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_im_we    = r_im_we;
    assign o_im_addr  = r_im_addr;
    assign o_im_wdata = r_im_wdata;
    assign o_cpu_en   = r_cpu_en;
    assign o_cpu_rst  = r_cpu_rst;
    assign o_reg_addr = r_reg_addr;
    assign o_mem_addr = r_mem_addr;
    assign o_busy     = r_busy;

endmodule

`default_nettype wire

// File: doc/mips_debug_ctrl.md
Name: mips_debug_ctrl

Overview:
- Debug controller that sits between the UART byte link and the MIPS pipeline inside Top_MIPS.
- Decodes host command bytes, loads program words into instruction memory, and runs the CPU either continuously until HALT or one clock at a time.
- After every run or step it streams the PC, the register file and data memory back to the host.
- It is the only block that drives CPU enable, CPU reset and instruction-memory writes.

Parameters:
- NBITS, 32, datapath/word width.
- CELDAS_REG, 32, register-file entries dumped.
- CELDAS_M, 70, data-memory words dumped.
- IM_ABITS, 8, instruction-memory address width.
- RBITS, 5, register address width.
- MBITS, 7, data-memory address width (ceil log2 CELDAS_M).

Ports:
- basys_clk  in  1  system clock; all logic on the rising edge.
- basys_reset  in  1  asynchronous, active-low reset.
- i_rx_data  in  8  received UART byte.
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid.
- o_tx_data  out  8  byte to transmit.
- o_tx_valid  out  1  o_tx_data valid; held until accepted.
- i_tx_ready  in  1  UART TX accepts the byte in any cycle where valid and ready are both high.
- o_im_we  out  1  instruction-memory write strobe.
- o_im_addr  out  IM_ABITS  instruction-memory write address.
- o_im_wdata  out  NBITS  instruction word.
- o_cpu_en  out  1  pipeline clock-enable.
- o_cpu_rst  out  1  active-high pipeline reset pulse.
- i_halt  in  1  HALT instruction reached write-back (level).
- i_pc  in  NBITS  current PC.
- o_reg_addr  out  RBITS  register-file debug read address.
- i_reg_data  in  NBITS  register read data, valid 1 cycle after address.
- o_mem_addr  out  MBITS  data-memory debug read address.
- i_mem_data  in  NBITS  memory read data, valid 1 cycle after address.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (basys_reset=0, async): state=IDLE and every output 0, including counters and the shift register.
- All outputs are registered.
- IDLE decodes the byte on the cycle i_rx_valid is high:
  - 0x4C 'L': go to LD_CNT.
  - 0x53 'S': go to STEP.
  - 0x43 'C': go to RUN.
  - 0x52 'R': o_cpu_rst=1 for exactly 1 cycle, then IDLE.
  - Any other byte is ignored.
- LD_CNT: the next rx byte is word count N.
  - N=0: return to IDLE with no writes.
  - Otherwise go to LD_BYTE with address counter=0.
- LD_BYTE: shifts in 4 bytes per word, MSB first.
  - On the 4th byte, o_im_we=1 for 1 cycle with o_im_addr=counter and o_im_wdata=the assembled word.
  - The counter then increments; after N words, return to IDLE.
- STEP:
  - If i_halt=0: o_cpu_en=1 for exactly 1 cycle, then DUMP.
  - If i_halt=1: no enable pulse, go straight to DUMP.
- RUN:
  - o_cpu_en=1 starting the cycle after the command, while i_halt=0.
  - When i_halt is sampled 1, o_cpu_en=0 on the next edge and the state moves to DUMP.
  - If i_halt=1 on entry, o_cpu_en is never asserted.
- DUMP: sends 4+4*CELDAS_REG+4*CELDAS_M bytes (412 at defaults), each word MSB first, in this order:
  - PC (i_pc captured on DUMP entry).
  - Registers 0..CELDAS_REG-1.
  - Memory 0..CELDAS_M-1.
- Per word:
  - Drive the address; capture data 1 cycle later into a 32-bit shift register.
  - Present 4 bytes on o_tx_data with o_tx_valid=1.
  - Advance a byte only on valid&ready.
  - o_tx_valid drops for at least the address/capture cycles between words.
- After the last byte is accepted: o_tx_valid=0, state=IDLE.
- o_tx_data and o_tx_valid stay stable while i_tx_ready=0.
- Rx bytes arriving in RUN, STEP or DUMP are dropped.
- o_reg_addr and o_mem_addr wrap to 0 after their final index.
- Reset mid-operation aborts immediately and clears everything. Partially loaded words are not written. o_cpu_en=0 at once.

Test Plan:
- Assert reset, release -> all outputs 0, o_busy=0. Send 0x00 and 0xFF -> state stays IDLE, no strobes.
- Send 4C 02 DE AD BE EF 00 00 00 01 -> exactly two o_im_we pulses: addr0=0xDEADBEEF, addr1=0x00000001. Then o_busy=0. Send 4C 00 -> no write.
- With i_pc=0x00000010, reg5=0x12345678, mem0=0xCAFEBABE, send 53 -> o_cpu_en high for exactly 1 cycle. Then 412 bytes: first bytes 00 00 00 10; bytes 24..27 = 12 34 56 78; bytes 132..135 = CA FE BA BE.
- Send 43, raise i_halt 10 cycles later -> o_cpu_en high for exactly 10 cycles, low the cycle after i_halt is seen, then the 412-byte dump. Repeat with i_halt already 1 -> zero enable cycles, dump only.
- During a dump, hold i_tx_ready low for 20 cycles mid-word -> o_tx_data/o_tx_valid unchanged, and the host byte stream is identical to the no-backpressure run.
- Pull reset low after 3 of the 4 bytes of word 1 in a load -> no o_im_we, all outputs 0. After release, 52 -> o_cpu_rst pulses for exactly 1 cycle.
